// File: rtl/fss_pkg.sv
// ---------------------------------------------------------------------------
// fss_pkg
// Shared types for the feature-map stream source:
//   fss_state_t : replay controller states (IDLE, RUN, DRAIN)
//   fss_beat_t  : one stream beat (sample plus channel/row/col tags)
//   COORD_W     : width of every coordinate tag on the stream
// The beat's data field is sized for the widest supported sample. The top
// level zero-extends into it and slices back out.
// ---------------------------------------------------------------------------
package fss_pkg;

    localparam int COORD_W        = 8;
    localparam int FSS_MAX_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } fss_state_t;

    typedef struct packed {
        logic [FSS_MAX_DATA_W-1:0] data;
        logic [COORD_W-1:0]        channel;
        logic [COORD_W-1:0]        row;
        logic [COORD_W-1:0]        col;
    } fss_beat_t;

endpackage

// File: rtl/fss_skid_buffer.sv
// ---------------------------------------------------------------------------
// fss_skid_buffer
// Two-entry buffer of stream beats that sits between the RAM read stage and
// the stream outputs. Its head entry drives the outputs directly, so a
// presented beat cannot change until it is accepted.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_inValid      : a beat is offered on i_inBeat this cycle
//   i_inBeat       : incoming beat
//   o_inReady      : a beat offered this cycle will be stored
//   o_outValid     : head entry holds a beat
//   o_outBeat      : head entry
//   i_outReady     : downstream accepts the head beat this cycle
//   o_almostFull   : occupancy after this edge will be 2, so a read issued
//                    now would have nowhere to land
//   o_count        : current occupancy (0..2)
// ---------------------------------------------------------------------------
module fss_skid_buffer
    import fss_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_inValid,
    input  fss_beat_t  i_inBeat,
    output logic       o_inReady,
    output logic       o_outValid,
    output fss_beat_t  o_outBeat,
    input  logic       i_outReady,
    output logic       o_almostFull,
    output logic [1:0] o_count
);

    fss_beat_t  r_head;
    fss_beat_t  r_tail;
    logic [1:0] r_count;

    logic       w_pop;
    logic       w_push;
    logic [1:0] w_countNext;

    assign w_pop       = (r_count != 2'd0) && i_outReady;
    assign o_inReady   = (r_count != 2'd2) || w_pop;
    assign w_push      = i_inValid && o_inReady;
    assign w_countNext = r_count + {1'b0, w_push} - {1'b0, w_pop};

    // The occupancy after this edge already counts the beat now in the RAM
    // stage. A read issued this cycle lands one edge later, so it is safe
    // only while that occupancy stays at one or below.
    assign o_almostFull = (w_countNext == 2'd2);

    // The head only moves on a pop, or when the buffer is empty. This keeps
    // the presented beat stable under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            r_count <= w_countNext;
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head <= i_inBeat;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head <= i_inBeat;
                    end else if (w_push) begin
                        r_tail <= i_inBeat;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (w_push) begin
                            r_tail <= i_inBeat;
                        end
                    end
                end
            endcase
        end
    end

    assign o_outValid = (r_count != 2'd0);
    assign o_outBeat  = r_head;
    assign o_count    = r_count;

endmodule

// File: rtl/feature_map_stream_source.sv
// ---------------------------------------------------------------------------
// feature_map_stream_source
// Holds one CHANNELS x HEIGHT x WIDTH feature map in an on-chip buffer that
// is loaded through a simple write port. On start, the map is replayed as a
// tagged pixel stream (channel innermost, then col, then row) that honours
// downstream back-pressure.
// Parameters: CHANNELS, HEIGHT, WIDTH (1..256 each), DATA_WIDTH (1..64).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_wr_en         : buffer write strobe (honoured only while idle)
//   i_wr_addr       : (row*WIDTH+col)*CHANNELS+ch; out-of-range is ignored
//   i_wr_data       : write sample
//   i_start         : begin replay (pulse, honoured only while idle)
//   o_busy          : replay in progress
//   o_done          : one-cycle pulse after the last beat is accepted
//   o_valid_out     : stream beat valid
//   o_data_out      : sample
//   o_channel_out   : channel tag
//   o_row_out       : row tag
//   o_col_out       : column tag
//   i_ready_in      : downstream ready; a beat moves on valid && ready
//   o_stall_cycles  : (FSS_STALL_CNT_EN only) saturating count of cycles
//                     with valid high and ready low in the current replay
// Build option: define FSS_STALL_CNT_EN to add the stall counter.
// ---------------------------------------------------------------------------
module feature_map_stream_source
    import fss_pkg::*;
#(
    parameter  int CHANNELS   = 16,
    parameter  int HEIGHT     = 8,
    parameter  int WIDTH      = 8,
    parameter  int DATA_WIDTH = 16,
    localparam int DEPTH      = CHANNELS * HEIGHT * WIDTH,
    localparam int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_valid_out,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic [COORD_W-1:0]    o_channel_out,
    output logic [COORD_W-1:0]    o_row_out,
    output logic [COORD_W-1:0]    o_col_out,
    input  logic                  i_ready_in
`ifdef FSS_STALL_CNT_EN
    ,
    output logic [31:0]           o_stall_cycles
`endif
);

    fss_state_t            r_state;
    fss_state_t            w_stateNext;

    logic [ADDR_W-1:0]     r_rdAddr;
    logic [COORD_W-1:0]    r_ch;
    logic [COORD_W-1:0]    r_col;
    logic [COORD_W-1:0]    r_row;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_ramQ;
    logic                  r_rdValid;
    logic [COORD_W-1:0]    r_rdCh;
    logic [COORD_W-1:0]    r_rdCol;
    logic [COORD_W-1:0]    r_rdRow;
    logic                  r_done;

    logic                  w_rdEn;
    logic                  w_wrEn;
    logic                  w_acceptStart;
    logic                  w_lastXfer;

    fss_beat_t             w_sbIn;
    fss_beat_t             w_sbOut;
    logic                  w_sbValid;
    logic                  w_sbAlmostFull;
    logic [1:0]            w_sbCount;
    logic                  w_unusedSbInReady;

    assign w_acceptStart = (r_state == IDLE) && i_start;
    assign w_wrEn        = i_wr_en && (r_state == IDLE) &&
                           ({1'b0, i_wr_addr} < (ADDR_W + 1)'(DEPTH));

    // The final beat is leaving: nothing more is being read, nothing is in
    // the RAM stage, and the skid buffer holds only the beat now accepted.
    assign w_lastXfer = (r_state == DRAIN) && !r_rdValid &&
                        (w_sbCount == 2'd1) && w_sbValid && i_ready_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_rdEn      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                if (!w_sbAlmostFull) begin
                    w_rdEn = 1'b1;
                    if (r_rdAddr == ADDR_W'(DEPTH - 1)) begin
                        w_stateNext = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_lastXfer) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Read address and the coordinates of the beat it fetches advance
    // together. The tags are therefore derived here, not from the address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdAddr <= '0;
            r_ch     <= '0;
            r_col    <= '0;
            r_row    <= '0;
        end else if (w_acceptStart) begin
            r_rdAddr <= '0;
            r_ch     <= '0;
            r_col    <= '0;
            r_row    <= '0;
        end else if (w_rdEn) begin
            r_rdAddr <= r_rdAddr + ADDR_W'(1);
            if (r_ch == COORD_W'(CHANNELS - 1)) begin
                r_ch <= '0;
                if (r_col == COORD_W'(WIDTH - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + COORD_W'(1);
                end else begin
                    r_col <= r_col + COORD_W'(1);
                end
            end else begin
                r_ch <= r_ch + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (w_rdEn) begin
            r_ramQ <= r_mem[r_rdAddr];
        end
    end

    // The tags ride alongside the RAM read so that they line up with r_ramQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdValid <= 1'b0;
            r_rdCh    <= '0;
            r_rdCol   <= '0;
            r_rdRow   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_rdValid <= w_rdEn;
            r_done    <= w_lastXfer;
            if (w_rdEn) begin
                r_rdCh  <= r_ch;
                r_rdCol <= r_col;
                r_rdRow <= r_row;
            end
        end
    end

    always_comb begin
        w_sbIn         = '0;
        w_sbIn.data    = FSS_MAX_DATA_W'(r_ramQ);
        w_sbIn.channel = r_rdCh;
        w_sbIn.row     = r_rdRow;
        w_sbIn.col     = r_rdCol;
    end

    fss_skid_buffer u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_inValid    (r_rdValid),
        .i_inBeat     (w_sbIn),
        .o_inReady    (w_unusedSbInReady),
        .o_outValid   (w_sbValid),
        .o_outBeat    (w_sbOut),
        .i_outReady   (i_ready_in),
        .o_almostFull (w_sbAlmostFull),
        .o_count      (w_sbCount)
    );

    generate
        if (DATA_WIDTH < FSS_MAX_DATA_W) begin : g_dataPad
            logic [FSS_MAX_DATA_W-DATA_WIDTH-1:0] w_unusedDataHi;
            assign w_unusedDataHi = w_sbOut.data[FSS_MAX_DATA_W-1:DATA_WIDTH];
        end
    endgenerate

    assign o_busy        = (r_state != IDLE);
    assign o_done        = r_done;
    assign o_valid_out   = w_sbValid;
    assign o_data_out    = w_sbOut.data[DATA_WIDTH-1:0];
    assign o_channel_out = w_sbOut.channel;
    assign o_row_out     = w_sbOut.row;
    assign o_col_out     = w_sbOut.col;

`ifdef FSS_STALL_CNT_EN
    logic [31:0] r_stallCycles;

    // Cleared when a replay is accepted, held after done, sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCycles <= '0;
        end else if (w_acceptStart) begin
            r_stallCycles <= '0;
        end else if (w_sbValid && !i_ready_in && (r_stallCycles != '1)) begin
            r_stallCycles <= r_stallCycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stallCycles;
`endif

endmodule

// File: tb/tb_feature_map_stream_source.sv
// ---------------------------------------------------------------------------
// tb_feature_map_stream_source
// Drives two instances of the stream source: a 2x2x2 map, and a 3x1x256 map
// that crosses the 8-bit column range. It checks each accepted beat against
// a reference computed from the beat index: the sample comes from the
// bench's copy of the buffer, and the tags are the index decomposed as
// channel, then col, then row. Build with FSS_STALL_CNT_EN to also check
// the stall counter.
// ---------------------------------------------------------------------------
module tb_feature_map_stream_source;

    localparam int C  = 2;
    localparam int H  = 2;
    localparam int W  = 2;
    localparam int D  = C * H * W;
    localparam int WC = 3;
    localparam int WH = 1;
    localparam int WW = 256;
    localparam int WD = WC * WH * WW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN;

    logic        sWrEn;
    logic [2:0]  sWrAddr;
    logic [15:0] sWrData;
    logic        sStart;
    logic        sReady;
    logic        sBusy;
    logic        sDone;
    logic        sValid;
    logic [15:0] sData;
    logic [7:0]  sCh;
    logic [7:0]  sRow;
    logic [7:0]  sCol;

    logic        wWrEn;
    logic [9:0]  wWrAddr;
    logic [15:0] wWrData;
    logic        wStart;
    logic        wReady;
    logic        wBusy;
    logic        wDone;
    logic        wValid;
    logic [15:0] wData;
    logic [7:0]  wCh;
    logic [7:0]  wRow;
    logic [7:0]  wCol;

`ifdef FSS_STALL_CNT_EN
    logic [31:0] sStall;
    logic [31:0] wStall;
`endif

    logic [15:0] smallMem [D];
    logic [15:0] wideMem  [WD];

    int nChecks = 0;
    int nBad    = 0;

    feature_map_stream_source #(
        .CHANNELS(C), .HEIGHT(H), .WIDTH(W), .DATA_WIDTH(16)
    ) dut (
        .clk           (clk),
        .rst_n         (rstN),
        .i_wr_en       (sWrEn),
        .i_wr_addr     (sWrAddr),
        .i_wr_data     (sWrData),
        .i_start       (sStart),
        .o_busy        (sBusy),
        .o_done        (sDone),
        .o_valid_out   (sValid),
        .o_data_out    (sData),
        .o_channel_out (sCh),
        .o_row_out     (sRow),
        .o_col_out     (sCol),
        .i_ready_in    (sReady)
`ifdef FSS_STALL_CNT_EN
        ,
        .o_stall_cycles(sStall)
`endif
    );

    feature_map_stream_source #(
        .CHANNELS(WC), .HEIGHT(WH), .WIDTH(WW), .DATA_WIDTH(16)
    ) dutWide (
        .clk           (clk),
        .rst_n         (rstN),
        .i_wr_en       (wWrEn),
        .i_wr_addr     (wWrAddr),
        .i_wr_data     (wWrData),
        .i_start       (wStart),
        .o_busy        (wBusy),
        .o_done        (wDone),
        .o_valid_out   (wValid),
        .o_data_out    (wData),
        .o_channel_out (wCh),
        .o_row_out     (wRow),
        .o_col_out     (wCol),
        .i_ready_in    (wReady)
`ifdef FSS_STALL_CNT_EN
        ,
        .o_stall_cycles(wStall)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nBad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic loadSmall();
        for (int k = 0; k < D; k++) begin
            @(negedge clk);
            sWrEn       = 1'b1;
            sWrAddr     = 3'(k);
            sWrData     = 16'(k);
            smallMem[k] = 16'(k);
        end
        @(negedge clk);
        sWrEn = 1'b0;
    endtask

    // mode 0: always ready; 1: hold ready low holdLen cycles while beat
    // holdBeat is presented; 2: random ready; 3: five isolated single-cycle
    // stalls. poke pulses start and a write to address 0 mid-replay.
    task automatic applyStimulus(input int mode, input int holdBeat,
                                 input int holdLen, input bit poke);
        int          cyc         = 0;
        int          beatIdx     = 0;
        int          holdCnt     = 0;
        int          stallsPut   = 0;
        int          stallModel  = 0;
        int          lastXferCyc = -10;
        bit          doneSeen    = 1'b0;
        bit          prevHeld    = 1'b0;
        logic [15:0] prevData    = '0;
        logic [7:0]  prevCh      = '0;
        logic [7:0]  prevRow     = '0;
        logic [7:0]  prevCol     = '0;
        @(negedge clk);
        sStart = 1'b1;
        sReady = 1'b1;
        while (!doneSeen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            sStart = 1'b0;
            sWrEn  = 1'b0;
            if (cyc == 1) begin
                checkOutput("busyAfterStart", 32'(sBusy), 32'd1);
                checkOutput("noValidCyc1", 32'(sValid), 32'd0);
`ifdef FSS_STALL_CNT_EN
                checkOutput("stallCleared", sStall, 32'd0);
`endif
            end
            if (cyc == 2) checkOutput("noValidCyc2", 32'(sValid), 32'd0);
            if (cyc == 3) checkOutput("firstValid", 32'(sValid), 32'd1);
            if (prevHeld) begin
                checkOutput("holdValid", 32'(sValid), 32'd1);
                checkOutput("holdData", 32'(sData), 32'(prevData));
                checkOutput("holdTags", {8'd0, sCh, sRow, sCol},
                            {8'd0, prevCh, prevRow, prevCol});
            end
            if (sDone) begin
                doneSeen = 1'b1;
                prevHeld = 1'b0;
                checkOutput("doneAfterLast", 32'(lastXferCyc), 32'(cyc - 1));
                checkOutput("beatsAtDone", 32'(beatIdx), 32'(D));
                checkOutput("busyAtDone", 32'(sBusy), 32'd0);
`ifdef FSS_STALL_CNT_EN
                checkOutput("stallCount", sStall, 32'(stallModel));
`endif
            end else begin
                checkOutput("busyDuring", 32'(sBusy), 32'd1);
                if (poke && cyc == 3) begin
                    sStart  = 1'b1;
                    sWrEn   = 1'b1;
                    sWrAddr = 3'd0;
                    sWrData = 16'hFFFF;
                end
                case (mode)
                    1: begin
                        if (sValid && beatIdx == holdBeat && holdCnt < holdLen) begin
                            sReady = 1'b0;
                            holdCnt++;
                        end else begin
                            sReady = 1'b1;
                        end
                    end
                    2: sReady = ($urandom_range(0, 3) != 0);
                    3: begin
                        if (sValid && stallsPut < 5 && cyc >= 3 && (cyc % 2) == 1) begin
                            sReady = 1'b0;
                            stallsPut++;
                        end else begin
                            sReady = 1'b1;
                        end
                    end
                    default: sReady = 1'b1;
                endcase
                if (sValid && !sReady) stallModel++;
                prevHeld = sValid && !sReady;
                prevData = sData;
                prevCh   = sCh;
                prevRow  = sRow;
                prevCol  = sCol;
                if (sValid && sReady) begin
                    if (beatIdx < D) begin
                        checkOutput("beatData", 32'(sData), 32'(smallMem[beatIdx]));
                        checkOutput("beatCh", 32'(sCh), 32'(beatIdx % C));
                        checkOutput("beatCol", 32'(sCol), 32'((beatIdx / C) % W));
                        checkOutput("beatRow", 32'(sRow), 32'(beatIdx / (C * W)));
                    end else begin
                        checkOutput("extraBeat", 32'(beatIdx), 32'(D - 1));
                    end
                    beatIdx++;
                    lastXferCyc = cyc;
                end
            end
        end
        sReady = 1'b1;
        if (!doneSeen) checkOutput("replayTimeout", 32'd0, 32'd1);
        repeat (2) begin
            @(negedge clk);
            checkOutput("doneSingle", 32'(sDone), 32'd0);
            checkOutput("idleAfter", {30'd0, sBusy, sValid}, 32'd0);
`ifdef FSS_STALL_CNT_EN
            checkOutput("stallHeld", sStall, 32'(stallModel));
`endif
        end
    endtask

    task automatic resetMidReplay();
        int guard = 0;
        @(negedge clk);
        sStart = 1'b1;
        sReady = 1'b1;
        @(negedge clk);
        sStart = 1'b0;
        while (!(sValid && sData == smallMem[4]) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reachBeat4", 32'(sData), 32'(smallMem[4]));
        rstN = 1'b0;
        #1;
        checkOutput("rstValid", 32'(sValid), 32'd0);
        checkOutput("rstBusy", 32'(sBusy), 32'd0);
        checkOutput("rstDone", 32'(sDone), 32'd0);
        checkOutput("rstData", 32'(sData), 32'd0);
        checkOutput("rstTags", {8'd0, sCh, sRow, sCol}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("rstNoDone", 32'(sDone), 32'd0);
        end
        rstN = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("postRstQuiet", {29'd0, sDone, sBusy, sValid}, 32'd0);
        end
    endtask

    task automatic runWide();
        int cyc      = 0;
        int beatIdx  = 0;
        int maxCol   = 0;
        bit doneSeen = 1'b0;
        for (int k = 0; k < WD; k++) begin
            @(negedge clk);
            wWrEn      = 1'b1;
            wWrAddr    = 10'(k);
            wWrData    = 16'($urandom);
            wideMem[k] = wWrData;
        end
        @(negedge clk);
        wWrAddr = 10'd1000;
        wWrData = 16'hDEAD;
        @(negedge clk);
        wWrEn  = 1'b0;
        wStart = 1'b1;
        wReady = 1'b1;
        while (!doneSeen && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            wStart = 1'b0;
            if (cyc == 3) checkOutput("wideFirstValid", 32'(wValid), 32'd1);
            if (wDone) begin
                doneSeen = 1'b1;
                checkOutput("wideBeatsAtDone", 32'(beatIdx), 32'(WD));
                checkOutput("wideBusyAtDone", 32'(wBusy), 32'd0);
            end else begin
                wReady = ($urandom_range(0, 3) != 0);
                if (wValid && wReady) begin
                    if (beatIdx < WD) begin
                        checkOutput("wideData", 32'(wData), 32'(wideMem[beatIdx]));
                        checkOutput("wideCh", 32'(wCh), 32'(beatIdx % WC));
                        checkOutput("wideCol", 32'(wCol), 32'((beatIdx / WC) % WW));
                        checkOutput("wideRow", 32'(wRow), 32'(beatIdx / (WC * WW)));
                        if (int'(wCol) > maxCol) maxCol = int'(wCol);
                    end else begin
                        checkOutput("wideExtraBeat", 32'(beatIdx), 32'(WD - 1));
                    end
                    beatIdx++;
                end
            end
        end
        wReady = 1'b1;
        if (!doneSeen) checkOutput("wideTimeout", 32'd0, 32'd1);
        checkOutput("wideMaxCol", 32'(maxCol), 32'd255);
`ifdef FSS_STALL_CNT_EN
        $display("[TB] wide replay stall cycles %0d", wStall);
`endif
    endtask

    initial begin : main
        rstN    = 1'b0;
        sWrEn   = 1'b0;
        sWrAddr = '0;
        sWrData = '0;
        sStart  = 1'b0;
        sReady  = 1'b1;
        wWrEn   = 1'b0;
        wWrAddr = '0;
        wWrData = '0;
        wStart  = 1'b0;
        wReady  = 1'b1;
        #1;
        checkOutput("resetValid", 32'(sValid), 32'd0);
        checkOutput("resetBusy", 32'(sBusy), 32'd0);
        checkOutput("resetDone", 32'(sDone), 32'd0);
        checkOutput("resetData", 32'(sData), 32'd0);
        checkOutput("resetTags", {8'd0, sCh, sRow, sCol}, 32'd0);
`ifdef FSS_STALL_CNT_EN
        checkOutput("resetStall", sStall, 32'd0);
`endif
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        $display("[TB] loading small map");
        loadSmall();
        $display("[TB] basic replay");
        applyStimulus(0, 0, 0, 1'b0);
        $display("[TB] back-pressure at beat 3");
        applyStimulus(1, 3, 10, 1'b0);
        $display("[TB] random ready");
        applyStimulus(2, 0, 0, 1'b0);
        applyStimulus(2, 0, 0, 1'b0);
        $display("[TB] start and write during replay");
        applyStimulus(2, 0, 0, 1'b1);
        applyStimulus(0, 0, 0, 1'b0);
        $display("[TB] reset mid-replay");
        resetMidReplay();
        applyStimulus(0, 0, 0, 1'b0);
        $display("[TB] isolated stalls");
        applyStimulus(3, 0, 0, 1'b0);
        applyStimulus(0, 0, 0, 1'b0);
        $display("[TB] wide map");
        runWide();

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
